star_data_server: RTL and testbench



---
 rtl/star_data_server.sv | 168 ++++++++++++++++
 tb/tb_star_data_server.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/star_data_server.sv
// star_data_server
// Responder side of the STAR image-fetch interface. The host streams a byte
// image in over a valid/ready handshake (LOAD). The fetch engine then reads it
// back with zero-latency combinational reads (SERVE). Request activity and
// out-of-range accesses are tracked until the consumer raises finish (DONE).
// A load_start pulse in DONE re-arms loading.
//
// Ports:
//   clk        in   1     single clock, posedge
//   reset      in   1     asynchronous, active-high
//   load_valid in   1     host byte valid
//   load_data  in   8     host byte
//   load_ready out  1     block accepts a host byte (registered state decode)
//   load_start in   1     re-arms loading when in DONE
//   data_req   in   1     consumer fetch request
//   data_addr  in   AW    consumer byte address
//   data       out  8     byte served to the consumer (combinational read)
//   finish     in   1     consumer done, level
//   mem_ready  out  1     image loaded and being served (registered)
//   req_count  out  AW+1  serviced requests, saturating
//   addr_err   out  1     sticky out-of-range request flag
module star_data_server #(
  parameter int DEPTH    = 512,
  parameter int AW       = 9,
  parameter int LOAD_LEN = 512
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          load_valid,
  input  logic [7:0]    load_data,
  output logic          load_ready,
  input  logic          load_start,
  input  logic          data_req,
  input  logic [AW-1:0] data_addr,
  output logic [7:0]    data,
  input  logic          finish,
  output logic          mem_ready,
  output logic [AW:0]   req_count,
  output logic          addr_err
);

  typedef enum logic [1:0] {
    ST_LOAD  = 2'd0,
    ST_SERVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // LOAD_LEN may equal 2^AW, so the range bound is held one bit wider.
  localparam logic [AW-1:0] LAST_PTR = AW'(LOAD_LEN - 1);
  localparam logic [AW:0]   LEN_W    = (AW+1)'(LOAD_LEN);
  localparam logic [AW:0]   CNT_MAX  = {(AW+1){1'b1}};

  state_t        state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0]   req_count_q, req_count_d;
  logic          addr_err_q, addr_err_d;
  logic          load_ready_q;
  logic          mem_ready_q;
  logic          wr_en_s;
  logic          addr_oob_s;
  logic [7:0]    data_s;

  // Image store; intentionally not reset.
  logic [7:0] mem [DEPTH];

  assign wr_en_s    = (state_q == ST_LOAD) && load_valid && load_ready_q;
  assign addr_oob_s = ({1'b0, data_addr} >= LEN_W);

  // Next-state and bookkeeping logic.
  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    req_count_d = req_count_q;
    addr_err_d  = addr_err_q;
    case (state_q)
      ST_LOAD: begin
        if (wr_en_s) begin
          if (wr_ptr_q == LAST_PTR) begin
            state_d  = ST_SERVE;
            wr_ptr_d = {AW{1'b0}};
          end else begin
            wr_ptr_d = wr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
          end
        end else begin
          wr_ptr_d = wr_ptr_q;
        end
      end
      ST_SERVE: begin
        // A request in the same cycle as finish is still counted.
        if (data_req) begin
          if (req_count_q != CNT_MAX) begin
            req_count_d = req_count_q + {{AW{1'b0}}, 1'b1};
          end else begin
            req_count_d = req_count_q;
          end
          if (addr_oob_s) begin
            addr_err_d = 1'b1;
          end else begin
            addr_err_d = addr_err_q;
          end
        end else begin
          req_count_d = req_count_q;
        end
        if (finish) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_SERVE;
        end
      end
      ST_DONE: begin
        if (load_start) begin
          state_d     = ST_LOAD;
          wr_ptr_d    = {AW{1'b0}};
          req_count_d = {(AW+1){1'b0}};
          addr_err_d  = 1'b0;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  // State, counters and registered status decodes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_LOAD;
      wr_ptr_q     <= {AW{1'b0}};
      req_count_q  <= {(AW+1){1'b0}};
      addr_err_q   <= 1'b0;
      load_ready_q <= 1'b1;
      mem_ready_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      req_count_q  <= req_count_d;
      addr_err_q   <= addr_err_d;
      load_ready_q <= (state_d == ST_LOAD);
      mem_ready_q  <= (state_d == ST_SERVE);
    end
  end

  // Image write port; only active while loading.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem[wr_ptr_q] <= load_data;
    end
  end

  // Zero-latency read; out-of-range and non-SERVE cycles return zero.
  always_comb begin
    data_s = 8'h00;
    if ((state_q == ST_SERVE) && !addr_oob_s) begin
      data_s = mem[data_addr];
    end else begin
      data_s = 8'h00;
    end
  end

  assign data       = data_s;
  assign load_ready = load_ready_q;
  assign mem_ready  = mem_ready_q;
  assign req_count  = req_count_q;
  assign addr_err   = addr_err_q;

endmodule

// File: tb/tb_star_data_server.sv
// Self-checking bench for star_data_server. Two instances: the default
// configuration (LOAD_LEN=512) and a short-image one (LOAD_LEN=256) that can
// see out-of-range addresses. Expected values come from a reference image
// array and plain counters kept in the bench.
module tb_star_data_server;

  logic       clk;
  logic       reset;

  // Instance 1: LOAD_LEN = 512
  logic       load_valid, load_start, data_req, finish;
  logic [7:0] load_data;
  logic [8:0] data_addr;
  logic       load_ready, mem_ready, addr_err;
  logic [7:0] data;
  logic [9:0] req_count;

  // Instance 2: LOAD_LEN = 256
  logic       load_valid2, load_start2, data_req2, finish2;
  logic [7:0] load_data2;
  logic [8:0] data_addr2;
  logic       load_ready2, mem_ready2, addr_err2;
  logic [7:0] data2;
  logic [9:0] req_count2;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [7:0] ref_mem  [512];
  logic [7:0] ref_mem2 [256];
  int exp_cnt, exp_err, exp_cnt2, exp_err2;

  star_data_server #(.DEPTH(512), .AW(9), .LOAD_LEN(512)) u_dut (
    .clk(clk), .reset(reset),
    .load_valid(load_valid), .load_data(load_data), .load_ready(load_ready),
    .load_start(load_start), .data_req(data_req), .data_addr(data_addr),
    .data(data), .finish(finish), .mem_ready(mem_ready),
    .req_count(req_count), .addr_err(addr_err)
  );

  star_data_server #(.DEPTH(512), .AW(9), .LOAD_LEN(256)) u_dut2 (
    .clk(clk), .reset(reset),
    .load_valid(load_valid2), .load_data(load_data2), .load_ready(load_ready2),
    .load_start(load_start2), .data_req(data_req2), .data_addr(data_addr2),
    .data(data2), .finish(finish2), .mem_ready(mem_ready2),
    .req_count(req_count2), .addr_err(addr_err2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [8:0] a;
    logic       r;
    reset = 1'b1;
    load_valid = 1'b0; load_data = 8'h00; load_start = 1'b0;
    data_req = 1'b0; data_addr = 9'd0; finish = 1'b0;
    load_valid2 = 1'b0; load_data2 = 8'h00; load_start2 = 1'b0;
    data_req2 = 1'b0; data_addr2 = 9'd0; finish2 = 1'b0;

    // ---- Reset defaults ----
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_load_ready", load_ready, 1);
    chk("rst_mem_ready", mem_ready, 0);
    chk("rst_data", data, 0);
    chk("rst_req_count", req_count, 0);
    chk("rst_addr_err", addr_err, 0);
    chk("rst2_load_ready", load_ready2, 1);

    // ---- Load 512 bytes 8'h10+i with valid held high ----
    for (int i = 0; i < 512; i++) begin
      load_valid = 1'b1;
      load_data  = 8'(8'h10 + i);
      ref_mem[i] = 8'(8'h10 + i);
      if (i == 511) chk("load_mem_ready_before_last", mem_ready, 0);
      if (i == 256) chk("load_ready_mid", load_ready, 1);
      tick();
    end
    chk("load_mem_ready_after_last", mem_ready, 1);
    chk("load_ready_after_last", load_ready, 0);
    // valid still high with an extra byte: must not be taken
    load_data = 8'hEE;
    tick();
    load_valid = 1'b0;
    chk("extra_byte_mem_ready", mem_ready, 1);
    data_addr = 9'd5;
    #1;
    chk("serve_addr5", data, 8'h15);
    chk("serve_addr0_intact", ref_mem[0], 8'h10);

    // ---- Consumer fetch: address presented one cycle before data_req ----
    exp_cnt = 0; exp_err = 0;
    data_addr = 9'd0; data_req = 1'b0;
    #1;
    chk("fetch_pre_req", data, ref_mem[0]);
    tick();
    for (int i = 0; i < 16; i++) begin
      data_addr = 9'(i);
      data_req  = 1'b1;
      #1;
      chk("fetch_data", data, ref_mem[i]);
      exp_cnt++;
      tick();
    end
    data_req = 1'b0;
    chk("fetch_req_count", req_count, exp_cnt);
    chk("fetch_addr_err", addr_err, 0);

    // ---- Randomized reads against the reference image ----
    for (int i = 0; i < 60; i++) begin
      a = 9'($urandom_range(0, 511));
      r = 1'($urandom_range(0, 1));
      data_addr = a; data_req = r;
      #1;
      chk("rand_data", data, ref_mem[a]);
      if (r) exp_cnt++;
      tick();
      chk("rand_req_count", req_count, exp_cnt);
    end

    // ---- Finish (request coincident is counted) and reload ----
    finish = 1'b1; data_req = 1'b1; data_addr = 9'd3;
    exp_cnt++;
    tick();
    finish = 1'b0;
    chk("done_mem_ready", mem_ready, 0);
    chk("done_load_ready", load_ready, 0);
    chk("done_data", data, 0);
    chk("done_req_count", req_count, exp_cnt);
    load_start = 1'b0;
    tick(); // requests in DONE are not counted
    data_req = 1'b0;
    chk("done_req_count_hold", req_count, exp_cnt);
    chk("done_addr_err_hold", addr_err, exp_err);
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    chk("reload_load_ready", load_ready, 1);
    chk("reload_mem_ready", mem_ready, 0);
    chk("reload_req_count", req_count, 0);
    chk("reload_addr_err", addr_err, 0);

    // ---- Reset mid-load ----
    for (int i = 0; i < 100; i++) begin
      load_valid = 1'b1;
      load_data  = 8'($urandom_range(0, 255));
      tick();
    end
    load_valid = 1'b0;
    reset = 1'b1;
    #1;
    chk("midrst_load_ready", load_ready, 1);
    chk("midrst_mem_ready", mem_ready, 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 512; i++) begin
      load_valid = 1'b1;
      load_data  = 8'(8'hA0 + i);
      ref_mem[i] = 8'(8'hA0 + i);
      if (i == 411) chk("midrst_not_early_412", mem_ready, 0);
      if (i == 511) chk("midrst_not_early_511", mem_ready, 0);
      tick();
    end
    load_valid = 1'b0;
    chk("midrst_mem_ready", mem_ready, 1);
    data_addr = 9'd0;
    #1;
    chk("midrst_addr0", data, 8'hA0);
    data_addr = 9'd511;
    #1;
    chk("midrst_addr511", data, 8'h9F);

    // ---- Short image: out-of-range and saturation (instance 2) ----
    exp_cnt2 = 0; exp_err2 = 0;
    for (int i = 0; i < 256; i++) begin
      load_valid2 = 1'b1;
      load_data2  = 8'($urandom_range(0, 255));
      ref_mem2[i] = load_data2;
      tick();
    end
    load_valid2 = 1'b0;
    chk("short_mem_ready", mem_ready2, 1);
    chk("short_load_ready", load_ready2, 0);
    data_addr2 = 9'd256; data_req2 = 1'b0;
    #1;
    chk("short_oob_boundary_data", data2, 0);
    tick();
    chk("short_no_err_without_req", addr_err2, 0);
    data_addr2 = 9'd300; data_req2 = 1'b1;
    #1;
    chk("short_oob_data", data2, 0);
    chk("short_err_before_edge", addr_err2, 0);
    exp_cnt2++; exp_err2 = 1;
    tick();
    chk("short_oob_err", addr_err2, 1);
    for (int i = 0; i < 1100; i++) begin
      a = 9'($urandom_range(0, 255));
      data_addr2 = a; data_req2 = 1'b1;
      #1;
      if (i < 20) chk("short_valid_data", data2, ref_mem2[a[7:0]]);
      if (exp_cnt2 < 1023) exp_cnt2++;
      tick();
      if (i < 20) chk("short_err_sticky", addr_err2, exp_err2);
    end
    data_req2 = 1'b0;
    chk("short_req_count_sat", req_count2, exp_cnt2);
    chk("short_err_final", addr_err2, exp_err2);
    chk("dut1_untouched_count", req_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
